// File: rtl/blink_multi_ctrl.sv
// blink_multi_ctrl: multi-channel LED pattern generator.
//
// A shared prescaler produces a one-cycle tick every 2**CBITS clocks while en is high. Each
// channel has its own period/duty phase counter that advances on ticks in BLINK or BURST mode.
// BURST runs a programmed number of periods, then falls back to OFF with a done pulse.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   en            prescaler enable (low freezes prescaler and all phase counters)
//   cfg_we        one-cycle config write strobe
//   cfg_ch        target channel; values >= NCH are ignored
//   cfg_mode      0 OFF, 1 ON, 2 BLINK, 3 BURST
//   cfg_period    ticks per period (0 behaves as 1)
//   cfg_duty      ticks led is high per period
//   cfg_count     BURST period count
//   tick          registered prescaler wrap pulse
//   led           registered LED drive, one bit per channel
//   flg           one-cycle pulse when a channel phase wraps to 0
//   done          one-cycle pulse when a BURST completes
//   active        high while channel mode is BLINK or BURST
module blink_multi_ctrl #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CBITS = 14,
  parameter int unsigned PBITS = 8,
  parameter int unsigned NBITS = 8,
  localparam int unsigned CHW  = $clog2(NCH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [PBITS-1:0] cfg_period,
  input  logic [PBITS-1:0] cfg_duty,
  input  logic [NBITS-1:0] cfg_count,
  output logic             tick,
  output logic [NCH-1:0]   led,
  output logic [NCH-1:0]   flg,
  output logic [NCH-1:0]   done,
  output logic [NCH-1:0]   active
);

  typedef enum logic [1:0] {
    ModeOff   = 2'd0,
    ModeOn    = 2'd1,
    ModeBlink = 2'd2,
    ModeBurst = 2'd3
  } mode_e;

  logic [CBITS-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [NCH-1:0]   led_q, led_d;
  logic [NCH-1:0]   flg_q, flg_d;
  logic [NCH-1:0]   done_q, done_d;

  mode_e            mode_q   [NCH];
  mode_e            mode_d   [NCH];
  logic [PBITS-1:0] ph_q     [NCH];
  logic [PBITS-1:0] ph_d     [NCH];
  logic [PBITS-1:0] period_q [NCH];
  logic [PBITS-1:0] period_d [NCH];
  logic [PBITS-1:0] duty_q   [NCH];
  logic [PBITS-1:0] duty_d   [NCH];
  logic [NBITS-1:0] rem_q    [NCH];
  logic [NBITS-1:0] rem_d    [NCH];

  // Per-channel decode helpers, fully assigned every pass.
  logic [NCH-1:0] wr_sel;
  logic [NCH-1:0] run;
  logic [NCH-1:0] last_ph;

  always_comb begin
    cnt_d  = en ? cnt_q + CBITS'(1) : cnt_q;
    tick_d = en & (cnt_q == '1);

    for (int unsigned i = 0; i < NCH; i++) begin
      mode_d[i]   = mode_q[i];
      ph_d[i]     = ph_q[i];
      period_d[i] = period_q[i];
      duty_d[i]   = duty_q[i];
      rem_d[i]    = rem_q[i];
      flg_d[i]    = 1'b0;
      done_d[i]   = 1'b0;

      wr_sel[i]  = cfg_we && (cfg_ch == CHW'(i));
      run[i]     = tick_q && ((mode_q[i] == ModeBlink) || (mode_q[i] == ModeBurst));
      // Period 0 behaves as period 1, so phase 0 is then also the last phase.
      last_ph[i] = (period_q[i] <= PBITS'(1)) ? (ph_q[i] == '0)
                                              : (ph_q[i] == period_q[i] - PBITS'(1));

      // LED follows the current (pre-update) phase, so it lags ph by one cycle.
      unique case (mode_q[i])
        ModeOff:              led_d[i] = 1'b0;
        ModeOn:               led_d[i] = 1'b1;
        ModeBlink, ModeBurst: led_d[i] = (ph_q[i] < duty_q[i]);
      endcase

      // A write takes priority over a coincident tick: phase restarts, no flg/done.
      if (wr_sel[i]) begin
        if ((mode_e'(cfg_mode) == ModeBurst) && (cfg_count == '0)) begin
          mode_d[i] = ModeOff;
        end else begin
          mode_d[i] = mode_e'(cfg_mode);
        end
        period_d[i] = cfg_period;
        duty_d[i]   = cfg_duty;
        rem_d[i]    = cfg_count;
        ph_d[i]     = '0;
      end else if (run[i]) begin
        if (last_ph[i]) begin
          ph_d[i]  = '0;
          flg_d[i] = 1'b1;
          if (mode_q[i] == ModeBurst) begin
            rem_d[i] = rem_q[i] - NBITS'(1);
            if (rem_q[i] == NBITS'(1)) begin
              mode_d[i] = ModeOff;
              done_d[i] = 1'b1;
            end
          end
        end else begin
          ph_d[i] = ph_q[i] + PBITS'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      led_q  <= '0;
      flg_q  <= '0;
      done_q <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        mode_q[i]   <= ModeOff;
        ph_q[i]     <= '0;
        period_q[i] <= '0;
        duty_q[i]   <= '0;
        rem_q[i]    <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      led_q    <= led_d;
      flg_q    <= flg_d;
      done_q   <= done_d;
      mode_q   <= mode_d;
      ph_q     <= ph_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      rem_q    <= rem_d;
    end
  end

  // BLINK and BURST are the only encodings with bit 1 set.
  always_comb begin
    active = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      active[i] = mode_q[i][1];
    end
  end

  assign tick = tick_q;
  assign led  = led_q;
  assign flg  = flg_q;
  assign done = done_q;

endmodule

// File: tb/tb_blink_multi_ctrl.sv
module tb_blink_multi_ctrl;
  localparam int NCH   = 2;
  localparam int CBITS = 2;
  localparam int PBITS = 4;
  localparam int NBITS = 4;
  localparam int CHW   = $clog2(NCH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             cfg_we;
  logic [CHW-1:0]   cfg_ch;
  logic [1:0]       cfg_mode;
  logic [PBITS-1:0] cfg_period;
  logic [PBITS-1:0] cfg_duty;
  logic [NBITS-1:0] cfg_count;
  logic             tick;
  logic [NCH-1:0]   led;
  logic [NCH-1:0]   flg;
  logic [NCH-1:0]   done;
  logic [NCH-1:0]   active;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic e_led0, e_led1;

  blink_multi_ctrl #(
    .NCH  (NCH),
    .CBITS(CBITS),
    .PBITS(PBITS),
    .NBITS(NBITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_period(cfg_period),
    .cfg_duty  (cfg_duty),
    .cfg_count (cfg_count),
    .tick      (tick),
    .led       (led),
    .flg       (flg),
    .done      (done),
    .active    (active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance to the next falling edge (sample point); any write strobe lasts one cycle.
  task automatic step();
    @(negedge clk);
    cyc++;
    cfg_we = 1'b0;
  endtask

  task automatic cfg_set(input logic [CHW-1:0] ch, input logic [1:0] mode,
                         input logic [PBITS-1:0] per, input logic [PBITS-1:0] dty,
                         input logic [NBITS-1:0] cnt);
    cfg_we     = 1'b1;
    cfg_ch     = ch;
    cfg_mode   = mode;
    cfg_period = per;
    cfg_duty   = dty;
    cfg_count  = cnt;
  endtask

  function automatic logic in_rng(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0;
    cfg_period = '0; cfg_duty = '0; cfg_count = '0;
    repeat (2) @(negedge clk);
    chk("rst_tick", tick, 0);
    chk("rst_led", led, 0);
    chk("rst_flg", flg, 0);
    chk("rst_done", done, 0);
    chk("rst_active", active, 0);
    rst = 1'b0;
    en  = 1'b1;
    cyc = 0;

    // Idle ticking, ch0 BLINK 4/2 from cycle 14, ch1 BURST 2/1/3 written on a tick cycle.
    while (cyc < 100) begin
      step();
      chk("tick", tick, cyc % 4 == 0);
      if (cyc <= 14) begin
        chk("idle_led", led, 0);
        chk("idle_flg", flg, 0);
        chk("idle_done", done, 0);
        chk("idle_active", active, (cyc == 14) ? 2'b01 : 2'b00);
      end else begin
        e_led0 = (cyc <= 21) ? 1'b1 : (cyc < 30) ? 1'b0 : (((cyc - 30) % 16) < 8);
        e_led1 = in_rng(cyc, 66, 69) || in_rng(cyc, 74, 77) || in_rng(cyc, 82, 85);
        chk("blink_led", led, {e_led1, e_led0});
        chk("blink_flg", flg, {(cyc == 73) || (cyc == 81) || (cyc == 89),
                               (cyc >= 29) && ((cyc - 29) % 16 == 0)});
        chk("burst_done", done, {cyc == 89, 1'b0});
        chk("burst_active", active, {in_rng(cyc, 65, 88), 1'b1});
      end
      if (cyc == 13) cfg_set(0, 2'd2, 4'd4, 4'd2, 4'd0);
      if (cyc == 64) cfg_set(1, 2'd3, 4'd2, 4'd1, 4'd3);
    end
    cfg_set(0, 2'd2, 4'd4, 4'd5, 4'd0);

    // Duty above period: led constant 1.
    while (cyc < 120) begin
      step();
      chk("tick", tick, cyc % 4 == 0);
      if (cyc >= 102) chk("full_led0", led[0], 1);
      chk("full_led1", led[1], 0);
      chk("full_flg", flg, {1'b0, cyc == 117});
      chk("full_done", done, 0);
      chk("full_active", active, 2'b01);
    end
    cfg_set(0, 2'd2, 4'd0, 4'd0, 4'd0);

    // Period 0, duty 0: led 0, flg every tick; out-of-range channel write ignored.
    while (cyc < 140) begin
      step();
      chk("zero_led", led, {1'b0, cyc == 121});
      chk("zero_flg", flg, {1'b0, (cyc >= 125) && (cyc % 4 == 1)});
      chk("zero_active", active, 2'b01);
      if (cyc == 136) cfg_set(2, 2'd1, 4'd1, 4'd1, 4'd1);
    end
    cfg_set(0, 2'd2, 4'd2, 4'd1, 4'd0);

    // Writes landing on tick cycles, the second one where the phase would otherwise wrap.
    while (cyc < 158) begin
      step();
      chk("tick", tick, cyc % 4 == 0);
      e_led0 = in_rng(cyc, 142, 145) || in_rng(cyc, 150, 153) || (cyc == 158);
      chk("wrtick_led", led, {1'b0, e_led0});
      chk("wrtick_flg", flg, {1'b0, cyc == 157});
      chk("wrtick_done", done, 0);
      if (cyc == 148) cfg_set(0, 2'd2, 4'd2, 4'd1, 4'd0);
    end
    en = 1'b0;

    // Prescaler frozen: no ticks, phase held; config still accepted.
    while (cyc < 170) begin
      step();
      chk("frz_tick", tick, 0);
      chk("frz_led", led, {cyc >= 164, 1'b1});
      chk("frz_flg", flg, 0);
      chk("frz_active", active, 2'b01);
      if (cyc == 162) cfg_set(1, 2'd1, 4'd0, 4'd0, 4'd0);
    end
    en = 1'b1;

    // Resume, start a 2-period burst on ch1, then reset in the middle of it.
    while (cyc < 183) begin
      step();
      chk("tick", tick, cyc % 4 == 0);
      e_led0 = in_rng(cyc, 171, 173) || in_rng(cyc, 178, 181);
      e_led1 = in_rng(cyc, 171, 177) || in_rng(cyc, 182, 183);
      chk("res_led", led, {e_led1, e_led0});
      chk("res_flg", flg, {cyc == 181, cyc == 177});
      chk("res_done", done, 0);
      chk("res_active", active, {cyc >= 173, 1'b1});
      if (cyc == 172) cfg_set(1, 2'd3, 4'd2, 4'd1, 4'd2);
    end

    #2 rst = 1'b1;
    #1;
    chk("arst_tick", tick, 0);
    chk("arst_led", led, 0);
    chk("arst_flg", flg, 0);
    chk("arst_done", done, 0);
    chk("arst_active", active, 0);
    step();
    rst = 1'b0;
    repeat (12) begin
      step();
      chk("post_led", led, 0);
      chk("post_flg", flg, 0);
      chk("post_done", done, 0);
      chk("post_active", active, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
